// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: stall encodings,
// register bus width and controller state codes.
package pipe_ctrl_pkg;

  localparam int RegBusW = 32;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [RegBusW-1:0] ZeroWord = '0;

  // Bit i stops stage i (0 = PC ... 5 = WB); WB is never stopped.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIF   = 6'b000011;
  localparam logic [5:0] StallID   = 6'b000111;
  localparam logic [5:0] StallEX   = 6'b001111;
  localparam logic [5:0] StallMEM  = 6'b011111;

  typedef enum logic [1:0] {
    CtrlRun       = 2'd0,
    CtrlFlushWait = 2'd1,
    CtrlFlush     = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_stall_enc.sv
// Priority encoder from the four stage stall requests to the 6-bit stall
// vector; the furthest-downstream request wins (mem > ex > id > if).
module pipe_stall_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_id_i,
  input  logic       req_ex_i,
  input  logic       req_mem_i,
  output logic [5:0] stall_o
);

  always_comb begin
    stall_o = StallNone;
    if (req_mem_i)     stall_o = StallMEM;
    else if (req_ex_i) stall_o = StallEX;
    else if (req_id_i) stall_o = StallID;
    else if (req_if_i) stall_o = StallIF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, bus-safe flush sequencing,
// consecutive-stall watchdog and saturating stall-cycle counter.
//   state         | meaning
//   CtrlRun       | normal operation, stall from request encoder
//   CtrlFlushWait | flush pending, holding MEM until the data bus goes idle
//   CtrlFlush     | one-cycle flush pulse with redirect PC, no stalls
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_LIMIT = 1023,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               flush_req,
  input  logic [RegBusW-1:0] flush_pc,
  output logic [5:0]         stall,
  output logic               flush,
  output logic [RegBusW-1:0] new_pc,
  output logic               stall_timeout,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int WdW = $clog2(STALL_LIMIT + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(STALL_LIMIT);

  ctrl_state_e        state_q, state_d;
  logic [RegBusW-1:0] pc_q, pc_d;
  logic               flush_q;
  logic [WdW-1:0]     wd_q, wd_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         enc_stall;
  logic               stalled;

  pipe_stall_enc u_stall_enc (
    .req_if_i  (stallreq_if),
    .req_id_i  (stallreq_id),
    .req_ex_i  (stallreq_ex),
    .req_mem_i (stallreq_mem),
    .stall_o   (enc_stall)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stall   = StallNone;
    unique case (state_q)
      CtrlRun: begin
        stall = enc_stall;
        if (flush_req) begin
          pc_d    = flush_pc;
          state_d = stallreq_mem ? CtrlFlushWait : CtrlFlush;
        end
      end
      CtrlFlushWait: begin
        stall = StallMEM;
        if (!stallreq_mem) state_d = CtrlFlush;
      end
      CtrlFlush: begin
        stall   = StallNone;
        state_d = CtrlRun;
      end
      default: state_d = CtrlRun;
    endcase
    // Stall is combinational, so it must be masked explicitly while in reset.
    if (!rst) stall = StallNone;
  end

  always_comb begin
    stalled   = |stall;
    wd_d      = '0;
    if (stalled) wd_d = (wd_q == WdLimit) ? wd_q : wd_q + 1'b1;
    timeout_d = timeout_q | (wd_d == WdLimit);
    cnt_d     = cnt_q;
    if (stalled && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CtrlRun;
      pc_q      <= ZeroWord;
      flush_q   <= 1'b0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flush_q   <= (state_d == CtrlFlush);
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = pc_q;
  assign stall_timeout = timeout_q;
  assign stall_cycles  = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall encoding table plus flush, watchdog,
// counter saturation and asynchronous reset sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem, freq;
  logic [31:0] fpc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [3:0]  stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;   // {mem, ex, id, if}
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];

  pipe_ctrl #(.STALL_LIMIT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (req_if),
    .stallreq_id  (req_id),
    .stallreq_ex  (req_ex),
    .stallreq_mem (req_mem),
    .flush_req    (freq),
    .flush_pc     (fpc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic fr, input logic [31:0] pc);
    {req_mem, req_ex, req_id, req_if} = req;
    freq = fr;
    fpc  = pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 6'b000000};
    vecs[1]  = '{4'b0001, 6'b000011};
    vecs[2]  = '{4'b0010, 6'b000111};
    vecs[3]  = '{4'b0011, 6'b000111};
    vecs[4]  = '{4'b0100, 6'b001111};
    vecs[5]  = '{4'b0000, 6'b000000};
    vecs[6]  = '{4'b0110, 6'b001111};
    vecs[7]  = '{4'b1110, 6'b011111};
    vecs[8]  = '{4'b1000, 6'b011111};
    vecs[9]  = '{4'b1111, 6'b011111};
    vecs[10] = '{4'b0000, 6'b000000};

    // Reset state, with requests active to prove stall is masked.
    rst = 1'b1;
    drive(4'b1010, 1'b0, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("rst_stall", {26'd0, stall}, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_timeout", {31'd0, stall_timeout}, 32'h0);
    chk("rst_cycles", {28'd0, stall_cycles}, 32'h0);
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    rst = 1'b1;

    // Encoding table, checked in the same cycle the requests change.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].req, 1'b0, 32'h0);
      #1;
      chk($sformatf("enc_vec%0d", i), {26'd0, stall}, {26'd0, vecs[i].exp});
    end
    @(negedge clk);
    #1;
    chk("enc_cycles", {28'd0, stall_cycles}, 32'd8);
    chk("enc_no_timeout", {31'd0, stall_timeout}, 32'h0);

    // Idle flush.
    do_reset();
    @(negedge clk);
    drive(4'b0000, 1'b1, 32'h0000_0040);
    #1;
    chk("idle_req_stall", {26'd0, stall}, 32'h0);
    chk("idle_req_flush", {31'd0, flush}, 32'h0);
    @(negedge clk);
    drive(4'b0010, 1'b0, 32'h0);
    #1;
    chk("idle_flush", {31'd0, flush}, 32'h1);
    chk("idle_new_pc", new_pc, 32'h0000_0040);
    chk("idle_flush_stall", {26'd0, stall}, 32'h0);
    @(negedge clk);
    drive(4'b0001, 1'b0, 32'h0);
    #1;
    chk("idle_after_flush", {31'd0, flush}, 32'h0);
    chk("idle_back_run", {26'd0, stall}, 32'b000011);

    // Deferred flush behind a busy data bus; second request must be ignored.
    do_reset();
    @(negedge clk);
    drive(4'b1000, 1'b1, 32'h8000_0180);
    #1;
    chk("def_c0_stall", {26'd0, stall}, 32'b011111);
    @(negedge clk);
    drive(4'b1000, 1'b1, 32'h0000_1234);
    #1;
    chk("def_c1_stall", {26'd0, stall}, 32'b011111);
    chk("def_c1_flush", {31'd0, flush}, 32'h0);
    @(negedge clk);
    drive(4'b1000, 1'b0, 32'h0);
    #1;
    chk("def_c2_stall", {26'd0, stall}, 32'b011111);
    @(negedge clk);
    drive(4'b0010, 1'b0, 32'h0);
    #1;
    chk("def_c3_stall", {26'd0, stall}, 32'b011111);
    chk("def_c3_flush", {31'd0, flush}, 32'h0);
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    #1;
    chk("def_flush", {31'd0, flush}, 32'h1);
    chk("def_new_pc", new_pc, 32'h8000_0180);
    chk("def_flush_stall", {26'd0, stall}, 32'h0);
    @(negedge clk);
    #1;
    chk("def_after_flush", {31'd0, flush}, 32'h0);

    // Watchdog: 7-cycle burst stays clear, 8-cycle burst sets it sticky.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(4'b0001, 1'b0, 32'h0);
      #1;
      chk($sformatf("wd7_c%0d", i), {31'd0, stall_timeout}, 32'h0);
    end
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    #1;
    chk("wd7_end", {31'd0, stall_timeout}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(4'b0001, 1'b0, 32'h0);
      #1;
      chk($sformatf("wd8_c%0d", i), {31'd0, stall_timeout}, 32'h0);
    end
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    #1;
    chk("wd8_set", {31'd0, stall_timeout}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wd8_sticky%0d", i), {31'd0, stall_timeout}, 32'h1);
    end

    // Stall-cycle counter saturation at 4'hF.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(4'b1000, 1'b0, 32'h0);
      #1;
      chk($sformatf("cnt_c%0d", i), {28'd0, stall_cycles}, (i > 15) ? 32'd15 : 32'(i));
    end
    @(negedge clk);
    drive(4'b0000, 1'b0, 32'h0);
    #1;
    chk("cnt_sat", {28'd0, stall_cycles}, 32'd15);
    @(negedge clk);
    #1;
    chk("cnt_hold", {28'd0, stall_cycles}, 32'd15);

    // Asynchronous reset while in FLUSH_WAIT discards the pending flush.
    @(negedge clk);
    drive(4'b1000, 1'b1, 32'hCAFE_0000);
    #1;
    chk("arst_c0_stall", {26'd0, stall}, 32'b011111);
    @(negedge clk);
    drive(4'b1000, 1'b0, 32'h0);
    #1;
    chk("arst_pre_timeout", {31'd0, stall_timeout}, 32'h1);
    chk("arst_pre_pc", new_pc, 32'hCAFE_0000);
    #1 rst = 1'b0;
    #1;
    chk("arst_stall", {26'd0, stall}, 32'h0);
    chk("arst_flush", {31'd0, flush}, 32'h0);
    chk("arst_new_pc", new_pc, 32'h0);
    chk("arst_timeout", {31'd0, stall_timeout}, 32'h0);
    chk("arst_cycles", {28'd0, stall_cycles}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("arst_no_flush%0d", i), {31'd0, flush}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
